// File: rtl/id_ex_issue_reg_pkg.sv
// rtl/id_ex_issue_reg_pkg.sv - shared pipe types for the decode-to-execute issue register
package id_ex_issue_reg_pkg;

  localparam int ISSUE_DATA_W = 64;
  localparam int ISSUE_ADDR_W = 5;
  localparam int ISSUE_CTRL_W = 32;

  typedef logic [ISSUE_ADDR_W-1:0] creg_addr_t;

  typedef enum logic {
    PASS = 1'b0,
    HELD = 1'b1
  } issue_state_t;

  typedef struct packed {
    logic                    valid;
    logic [ISSUE_DATA_W-1:0] pc;
    creg_addr_t              rd;
    logic [ISSUE_CTRL_W-1:0] ctrl;
    logic [ISSUE_DATA_W-1:0] srca;
    logic [ISSUE_DATA_W-1:0] srcb;
    logic [ISSUE_DATA_W-1:0] csr;
  } issue_data_t;

  typedef struct packed {
    logic                    stall;
    logic                    clear;
    logic                    srca_mux;
    logic                    srcb_mux;
    logic                    csr_mux;
    logic [ISSUE_DATA_W-1:0] srca_fwd;
    logic [ISSUE_DATA_W-1:0] srcb_fwd;
    logic [ISSUE_DATA_W-1:0] csr_fwd;
  } hazard_data_out;

  // Saturating 32-bit increment used by the performance counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/id_ex_issue_reg_operand_latch.sv
// rtl/id_ex_issue_reg_operand_latch.sv - holds forwarded operands across an execute stall
module id_ex_issue_reg_operand_latch #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_capture,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_opa,
  input  logic [DATA_W-1:0] i_opb,
  input  logic [DATA_W-1:0] i_csr,
  output logic [DATA_W-1:0] o_opa,
  output logic [DATA_W-1:0] o_opb,
  output logic [DATA_W-1:0] o_csr,
  output logic              o_latch_valid
);

  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  logic [DATA_W-1:0] r_csr;
  logic              r_valid;

  // Capture once on entry to the hold; clear wins so a flush never leaves stale operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_csr   <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_csr   <= '0;
      r_valid <= 1'b0;
    end else if (i_capture) begin
      r_opa   <= i_opa;
      r_opb   <= i_opb;
      r_csr   <= i_csr;
      r_valid <= 1'b1;
    end
  end

  // Latched copy outranks both the register file value and any live forward.
  always_comb begin
    o_opa         = r_valid ? r_opa : i_opa;
    o_opb         = r_valid ? r_opb : i_opb;
    o_csr         = r_valid ? r_csr : i_csr;
    o_latch_valid = r_valid;
  end

endmodule

// File: rtl/id_ex_issue_reg.sv
// rtl/id_ex_issue_reg.sv - decode-to-execute issue register (optional ID_EX_PERF_EN counters)
module id_ex_issue_reg
  import id_ex_issue_reg_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] id_srca,
  input  logic [DATA_W-1:0] id_srcb,
  input  logic [DATA_W-1:0] id_csr,
  input  logic              hz_stall,
  input  logic              hz_clear,
  input  logic              hz_srca_mux,
  input  logic              hz_srcb_mux,
  input  logic              hz_csr_mux,
  input  logic [DATA_W-1:0] hz_srca_fwd,
  input  logic [DATA_W-1:0] hz_srcb_fwd,
  input  logic [DATA_W-1:0] hz_csr_fwd,
  input  logic              ex_busy,
  input  logic              flush,
  output logic              id_hold,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [ADDR_W-1:0] ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_srca,
  output logic [DATA_W-1:0] ex_srcb,
  output logic [DATA_W-1:0] ex_csr
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]       perf_bubble_cnt,
  output logic [31:0]       perf_hold_cnt
`endif
);

  issue_state_t      r_state;
  issue_state_t      w_state_nxt;
  logic              r_ex_valid;
  logic [DATA_W-1:0] r_ex_pc;
  logic [ADDR_W-1:0] r_ex_rd;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic [DATA_W-1:0] r_ex_srca;
  logic [DATA_W-1:0] r_ex_srcb;
  logic [DATA_W-1:0] r_ex_csr;

  logic              w_busy_hold;
  logic              w_stall;
  logic              w_any_hold;
  logic              w_capture;
  logic              w_clear;
  logic              w_latch_valid;
  logic [DATA_W-1:0] w_res_a;
  logic [DATA_W-1:0] w_res_b;
  logic [DATA_W-1:0] w_res_c;
  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;
  logic [DATA_W-1:0] w_csr;

  // Forward muxes and hold qualifiers; an empty execute slot never blocks.
  always_comb begin
    w_res_a     = hz_srca_mux ? hz_srca_fwd : id_srca;
    w_res_b     = hz_srcb_mux ? hz_srcb_fwd : id_srcb;
    w_res_c     = hz_csr_mux  ? hz_csr_fwd  : id_csr;
    w_busy_hold = ex_busy & r_ex_valid;
    w_stall     = hz_stall | hz_clear;
    w_any_hold  = w_busy_hold | w_stall;
    id_hold     = ~reset & ~flush & w_any_hold;
  end

  // Next state plus latch control: latch on entering a busy hold, release on the first free edge.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_clear     = flush;
    case (r_state)
      PASS: begin
        if (!flush && w_busy_hold && id_valid) begin
          w_state_nxt = HELD;
          w_capture   = 1'b1;
        end
      end
      HELD: begin
        if (flush) begin
          w_state_nxt = PASS;
        end else if (!w_any_hold) begin
          w_state_nxt = PASS;
          w_clear     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = PASS;
        w_clear     = 1'b1;
      end
    endcase
  end

  id_ex_issue_reg_operand_latch #(
    .DATA_W (DATA_W)
  ) u_operand_latch (
    .clk           (clk),
    .reset         (reset),
    .i_capture     (w_capture),
    .i_clear       (w_clear),
    .i_opa         (w_res_a),
    .i_opb         (w_res_b),
    .i_csr         (w_res_c),
    .o_opa         (w_opa),
    .o_opb         (w_opb),
    .o_csr         (w_csr),
    .o_latch_valid (w_latch_valid)
  );

  // Hold-state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= PASS;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pipeline register: flush, then busy hold, then bubble, then normal load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_valid <= 1'b0;
      r_ex_pc    <= '0;
      r_ex_rd    <= '0;
      r_ex_ctrl  <= '0;
      r_ex_srca  <= '0;
      r_ex_srcb  <= '0;
      r_ex_csr   <= '0;
    end else if (flush || (!w_busy_hold && w_stall)) begin
      r_ex_valid <= 1'b0;
      r_ex_pc    <= '0;
      r_ex_rd    <= '0;
      r_ex_ctrl  <= '0;
      r_ex_srca  <= '0;
      r_ex_srcb  <= '0;
      r_ex_csr   <= '0;
    end else if (!w_busy_hold) begin
      r_ex_valid <= id_valid;
      r_ex_pc    <= id_pc;
      r_ex_rd    <= id_rd;
      r_ex_ctrl  <= id_ctrl;
      r_ex_srca  <= w_opa;
      r_ex_srcb  <= w_opb;
      r_ex_csr   <= w_csr;
    end
  end

  assign ex_valid = r_ex_valid;
  assign ex_pc    = r_ex_pc;
  assign ex_rd    = r_ex_rd;
  assign ex_ctrl  = r_ex_ctrl;
  assign ex_srca  = r_ex_srca;
  assign ex_srcb  = r_ex_srcb;
  assign ex_csr   = r_ex_csr;

`ifdef ID_EX_PERF_EN
  logic [31:0] r_perf_bubble;
  logic [31:0] r_perf_hold;

  // Saturating bubble/hold counters; flush does not clear them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_bubble <= '0;
      r_perf_hold   <= '0;
    end else if (!flush) begin
      if (w_busy_hold) begin
        r_perf_hold <= sat_inc32(r_perf_hold);
      end else if (w_stall) begin
        r_perf_bubble <= sat_inc32(r_perf_bubble);
      end
    end
  end

  assign perf_bubble_cnt = r_perf_bubble;
  assign perf_hold_cnt   = r_perf_hold;
`else
  logic w_unused;
  assign w_unused = w_latch_valid;
`endif

endmodule

// File: tb/tb_id_ex_issue_reg.sv
// tb/tb_id_ex_issue_reg.sv - scoreboard bench for id_ex_issue_reg
module tb_id_ex_issue_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [4:0]  id_rd;
  logic [31:0] id_ctrl;
  logic [63:0] id_srca, id_srcb, id_csr;
  logic        hz_stall, hz_clear;
  logic        hz_srca_mux, hz_srcb_mux, hz_csr_mux;
  logic [63:0] hz_srca_fwd, hz_srcb_fwd, hz_csr_fwd;
  logic        ex_busy, flush;
  logic        id_hold, ex_valid;
  logic [63:0] ex_pc;
  logic [4:0]  ex_rd;
  logic [31:0] ex_ctrl;
  logic [63:0] ex_srca, ex_srcb, ex_csr;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_bubble_cnt, perf_hold_cnt;
`endif

  id_ex_issue_reg dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_rd(id_rd),
    .id_ctrl(id_ctrl), .id_srca(id_srca), .id_srcb(id_srcb), .id_csr(id_csr),
    .hz_stall(hz_stall), .hz_clear(hz_clear), .hz_srca_mux(hz_srca_mux),
    .hz_srcb_mux(hz_srcb_mux), .hz_csr_mux(hz_csr_mux), .hz_srca_fwd(hz_srca_fwd),
    .hz_srcb_fwd(hz_srcb_fwd), .hz_csr_fwd(hz_csr_fwd), .ex_busy(ex_busy),
    .flush(flush), .id_hold(id_hold), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_srca(ex_srca), .ex_srcb(ex_srcb),
    .ex_csr(ex_csr)
`ifdef ID_EX_PERF_EN
    , .perf_bubble_cnt(perf_bubble_cnt), .perf_hold_cnt(perf_hold_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [31:0] ctrl;
    logic [63:0] a, b, c;
    logic [31:0] pb, ph;
  } exp_t;

  typedef struct {
    logic [63:0] a, b, c;
  } ops_t;

  exp_t sb[$];
  ops_t held[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference view of what execute currently holds.
  exp_t m;
  logic last_hold;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m = '{v: 1'b0, pc: '0, rd: '0, ctrl: '0, a: '0, b: '0, c: '0, pb: '0, ph: '0};
    held.delete();
    last_hold = 1'b0;
  endtask

  task automatic clr_inputs();
    id_valid = 0; id_pc = '0; id_rd = '0; id_ctrl = '0;
    id_srca = '0; id_srcb = '0; id_csr = '0;
    hz_stall = 0; hz_clear = 0; hz_srca_mux = 0; hz_srcb_mux = 0; hz_csr_mux = 0;
    hz_srca_fwd = '0; hz_srcb_fwd = '0; hz_csr_fwd = '0;
    ex_busy = 0; flush = 0;
  endtask

  // Called just after a negedge with inputs applied; predicts the coming edge and waits for the next negedge.
  task automatic tick();
    logic busy_hold, stallv, exp_hold;
    ops_t r;
    #1;
    busy_hold = ex_busy && m.v;
    stallv    = hz_stall || hz_clear;
    exp_hold  = !flush && (busy_hold || stallv);
    chk("id_hold", {63'd0, id_hold}, {63'd0, exp_hold});
    r.a = hz_srca_mux ? hz_srca_fwd : id_srca;
    r.b = hz_srcb_mux ? hz_srcb_fwd : id_srcb;
    r.c = hz_csr_mux  ? hz_csr_fwd  : id_csr;
    if (flush) begin
      m.v = 1'b0;
      held.delete();
    end else if (busy_hold) begin
      if (held.size() == 0 && id_valid) held.push_back(r);
      if (m.ph != 32'hFFFF_FFFF) m.ph++;
    end else if (stallv) begin
      m.v = 1'b0;
      if (m.pb != 32'hFFFF_FFFF) m.pb++;
    end else begin
      if (held.size() != 0) begin
        r = held.pop_front();
      end
      m.v = id_valid; m.pc = id_pc; m.rd = id_rd; m.ctrl = id_ctrl;
      m.a = r.a; m.b = r.b; m.c = r.c;
    end
    last_hold = exp_hold;
    sb.push_back(m);
    @(negedge clk);
  endtask

  // Monitor: after each edge, compare the DUT against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ex_valid", {63'd0, ex_valid}, {63'd0, e.v});
        if (e.v) begin
          chk("ex_pc", ex_pc, e.pc);
          chk("ex_rd", {59'd0, ex_rd}, {59'd0, e.rd});
          chk("ex_ctrl", {32'd0, ex_ctrl}, {32'd0, e.ctrl});
          chk("ex_srca", ex_srca, e.a);
          chk("ex_srcb", ex_srcb, e.b);
          chk("ex_csr", ex_csr, e.c);
        end
`ifdef ID_EX_PERF_EN
        chk("perf_bubble", {32'd0, perf_bubble_cnt}, {32'd0, e.pb});
        chk("perf_hold", {32'd0, perf_hold_cnt}, {32'd0, e.ph});
`endif
      end
    end
  end

  task automatic new_instr(input logic [63:0] pc);
    id_valid = 1; id_pc = pc; id_rd = pc[6:2]; id_ctrl = pc[31:0] ^ 32'h5A5A_0000;
  endtask

  initial begin
    clr_inputs();
    model_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    chk("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
    chk("rst_ex_pc", ex_pc, 64'd0);
    chk("rst_ex_srca", ex_srca, 64'd0);
    chk("rst_id_hold", {63'd0, id_hold}, 64'd0);
    reset = 0;

    // Plain flow.
    new_instr(64'h8000_0000); id_srca = 64'd5;
    tick();
    // Forward select.
    new_instr(64'h8000_0004); id_srca = 64'd7; hz_srca_mux = 1; hz_srca_fwd = 64'hDEAD;
    tick();
    hz_srca_mux = 0;
    // Load-use bubble, then the same instruction reloads.
    new_instr(64'h8000_0008); id_srca = 64'd9; hz_stall = 1;
    tick();
    hz_stall = 0;
    tick();
    // Busy hold with a forward that retires after the first cycle.
    new_instr(64'h8000_000C);
    tick();
    new_instr(64'h8000_0010); id_srcb = 64'h11; hz_srcb_mux = 1; hz_srcb_fwd = 64'h42; ex_busy = 1;
    tick();
    hz_srcb_mux = 0; hz_srcb_fwd = 64'h99;
    tick();
    tick();
    ex_busy = 0;
    tick();
    // Flush while HELD, together with a stall.
    new_instr(64'h8000_0014); id_srca = 64'hAA; hz_srca_mux = 1; hz_srca_fwd = 64'hBB; ex_busy = 1;
    tick();
    flush = 1; hz_stall = 1;
    tick();
    flush = 0; hz_stall = 0; ex_busy = 0; hz_srca_mux = 0;
    new_instr(64'h8000_0018); id_srca = 64'h77;
    tick();

    // Randomized traffic; decode keeps its instruction whenever it was told to hold.
    for (int i = 0; i < 600; i++) begin
      if (!last_hold) begin
        id_valid = ($urandom_range(0, 9) != 0);
        id_pc    = {$urandom, $urandom};
        id_rd    = 5'($urandom);
        id_ctrl  = $urandom;
      end
      id_srca = {$urandom, $urandom}; id_srcb = {$urandom, $urandom}; id_csr = {$urandom, $urandom};
      hz_srca_fwd = {$urandom, $urandom}; hz_srcb_fwd = {$urandom, $urandom};
      hz_csr_fwd = {$urandom, $urandom};
      hz_srca_mux = $urandom_range(0, 1); hz_srcb_mux = $urandom_range(0, 1);
      hz_csr_mux = $urandom_range(0, 1);
      ex_busy  = ($urandom_range(0, 9) < 3);
      hz_stall = ($urandom_range(0, 19) < 3);
      hz_clear = ($urandom_range(0, 39) == 0);
      flush    = ($urandom_range(0, 24) == 0);
      tick();
    end

    // Asynchronous reset in the middle of a hold.
    clr_inputs();
    new_instr(64'h8000_0100);
    tick();
    new_instr(64'h8000_0104); hz_srcb_mux = 1; hz_srcb_fwd = 64'h1234; ex_busy = 1;
    tick();
    #2;
    reset = 1;
    #1;
    chk("async_ex_valid", {63'd0, ex_valid}, 64'd0);
    chk("async_id_hold", {63'd0, id_hold}, 64'd0);
`ifdef ID_EX_PERF_EN
    chk("async_perf_bubble", {32'd0, perf_bubble_cnt}, 64'd0);
    chk("async_perf_hold", {32'd0, perf_hold_cnt}, 64'd0);
`endif
    @(negedge clk);
    reset = 0;
    model_reset();
    clr_inputs();
    new_instr(64'h8000_0108); id_srcb = 64'h55;
    tick();
    tick();

    @(posedge clk);
    #2;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_issue_reg.md
Name: id_ex_issue_reg

Overview:
- Decode-to-execute pipeline register. It sits directly downstream of the hazard unit and consumes its stall, clear and forwarding outputs.
- Applies the srca/srcb/csr forward muxes to decoded operands and registers the result into execute.
- Holds on execute back-pressure. Inserts bubbles on load-use stalls and kills on branch/exception flush.
- While held, keeps a latched copy of the forwarded operands, so a forwarding producer that retires during the hold is not lost.

Parameters:
- DATA_W, 64, operand/data width.
- ADDR_W, 5, register index width (creg_addr_t).
- CTRL_W, 32, opaque decoded-control bundle width, passed through unchanged.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode holds a valid instruction.
- id_pc  in  DATA_W  decode PC.
- id_rd  in  ADDR_W  destination register.
- id_ctrl  in  CTRL_W  decoded control.
- id_srca, id_srcb, id_csr  in  DATA_W each  register-file / CSR-file read data.
- hz_stall, hz_clear  in  1 each  from the hazard unit (load-use).
- hz_srca_mux, hz_srcb_mux, hz_csr_mux  in  1 each  forward selects.
- hz_srca_fwd, hz_srcb_fwd, hz_csr_fwd  in  DATA_W each  forwarded data.
- ex_busy  in  1  execute cannot accept (multi-cycle mul/div).
- flush  in  1  redirect; kills decode and this register.
- id_hold  out  1  upstream (fetch/decode) must hold.
- ex_valid  out  1  registered valid to execute.
- ex_pc  out  DATA_W  registered PC.
- ex_rd  out  ADDR_W  registered destination.
- ex_ctrl  out  CTRL_W  registered control.
- ex_srca, ex_srcb, ex_csr  out  DATA_W each  registered resolved operands.

Behaviour:
- Reset (async): all ex_* outputs 0, ex_valid=0, FSM=PASS, operand latch cleared, latch_valid=0.
- Operand resolve (combinational): opa = hz_srca_mux ? hz_srca_fwd : id_srca; same rule for opb/csr.
- While latch_valid=1, the latched operand replaces the resolved one. The latched value has priority over both the RF value and the live forward.
- Register update priority at each clk edge, highest first:
  1. flush: ex_valid←0, latch cleared, FSM→PASS.
  2. ex_busy and ex_valid: all ex_* hold.
  3. hz_stall (equivalently hz_clear): ex_valid←0 bubble, other ex_* don't-care (drive 0).
  4. Otherwise: load ex_valid←id_valid, plus pc/rd/ctrl and the resolved operands.
- ex_busy with ex_valid=0 does not hold; the register loads normally (an empty slot cannot block).
- id_hold = ~flush & ((ex_busy & ex_valid) | hz_stall). Combinational, 0 during reset.
- FSM PASS→HELD: edge where ex_busy&ex_valid&id_valid&~flush. Capture opa/opb/csr into the latch and set latch_valid=1.
- FSM HELD→HELD: while hold persists. The latch is not rewritten.
- FSM HELD→PASS: first non-hold edge. The load uses the latched operands, then clears latch_valid. Also on flush.
- hz_stall arriving while in HELD: the latch is kept, since the instruction still waits.
- Load latency: 1 cycle from decode to ex_*. Back-to-back loads run at full throughput with no bubbles.
- flush and hz_stall in the same cycle: flush wins and id_hold=0.
- Reset asserted mid-hold: everything is cleared immediately. No partial state survives.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- When defined: adds outputs perf_bubble_cnt and perf_hold_cnt, each 32 bits, reset to 0.
  - perf_bubble_cnt increments on each hz_stall bubble edge.
  - perf_hold_cnt increments on each ex_busy hold edge.
  - Both saturate at 0xFFFF_FFFF and are not cleared by flush.
- When undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared pipes package gets:
  - issue_data_t struct (valid, pc, rd, ctrl, srca, srcb, csr).
  - issue_state_t enum {PASS, HELD}.
- The existing hazard_data_out struct is reused for the hz_* inputs.
- One sub-module: operand_latch (three DATA_W registers, latch_valid flag, capture/clear inputs, output mux).

Test Plan:
- Plain flow:
  - Stimulus: id_valid=1, pc=0x8000_0000, srca=5, no forward.
  - Response: next cycle ex_valid=1, ex_pc=0x8000_0000, ex_srca=5.
- Forward select:
  - Stimulus: hz_srca_mux=1, hz_srca_fwd=0xDEAD, id_srca=7.
  - Response: ex_srca=0xDEAD.
- Load-use bubble:
  - Stimulus: hz_stall=1 for one cycle.
  - Response: id_hold=1; next cycle ex_valid=0; following cycle the same instruction loads with ex_valid=1.
- Busy hold with retiring forward:
  - Stimulus: ex_busy=1 for 3 cycles; fwd=0x42 present only in the first cycle.
  - Response: ex_* unchanged for 3 cycles; after release ex_srcb=0x42, not the stale RF value.
- Flush during HELD:
  - Stimulus: flush=1.
  - Response: next cycle ex_valid=0, FSM PASS, latch_valid=0, id_hold=0.
- Async reset:
  - Stimulus: reset asserted mid-cycle while HELD.
  - Response: ex_valid=0 immediately, without waiting for clk; ID_EX_PERF_EN counters read 0.
